// File: rtl/text_stream_loader_if.sv
// text_stream_loader_if: beat-stream link from the boot/debug port into the
// text loader.
//   load_start : single-cycle pulse that restarts a load
//   load_end   : single-cycle pulse that marks the end of the stream
//   in_valid   : beat valid
//   in_data    : beat payload (IN_W bits)
//   in_ready   : beat accepted when in_valid & in_ready
// Modports: master drives the stream, slave (the loader) returns in_ready.
interface text_stream_loader_if #(
  parameter int IN_W = 8
);
  logic            load_start;
  logic            load_end;
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            in_ready;

  modport master (
    output load_start,
    output load_end,
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  load_start,
    input  load_end,
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/text_stream_loader.sv
// text_stream_loader: packs a narrow beat stream little-endian into words and
// writes them into an internal text RAM, with a registered read port for the
// instruction fetch stage.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   stream      : beat stream (load_start/load_end/in_valid/in_data/in_ready)
//   raddr       : byte read address; low BOFS_W bits ignored
//   rdata       : RAM word at raddr, one cycle later (read-before-write)
//   loading     : high in LOAD or FLUSH
//   load_done   : high in DONE
//   word_count  : words written since the last load_start (saturates at depth)
//   overflow    : sticky; a beat was offered while the RAM was full
module text_stream_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32,
  parameter int IN_W   = 8,
  parameter int BOFS_W = $clog2(WORD_W / 8)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  text_stream_loader_if.slave      stream,
  input  logic [ADDR_W+BOFS_W-1:0] raddr,
  output logic [WORD_W-1:0]        rdata,
  output logic                     loading,
  output logic                     load_done,
  output logic [ADDR_W:0]          word_count,
  output logic                     overflow
);

  localparam int LANES  = WORD_W / IN_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r, next_state_s;
  logic [LANE_W-1:0]   lane_r, lane_next_s;
  logic [WORD_W-1:0]   asm_r, asm_next_s, flush_word_s;
  logic [ADDR_W:0]     word_count_r, wptr_r;
  logic                overflow_r, loading_r, load_done_r;
  logic [WORD_W-1:0]   rdata_r;
  logic                full_s, in_ready_s, accept_s, lane_last_s;
  logic                we_s;
  logic [WORD_W-1:0]   wdata_s;
  logic [31:0]         flush_shift_s;
  logic [WORD_W-1:0]   mem [DEPTH];

  // Readiness depends only on state and counters so the source may wait on it.
  assign full_s      = (word_count_r == FULL_COUNT);
  assign in_ready_s  = (state_r == ST_LOAD) & ~full_s;
  // load_start wins the cycle: a beat offered alongside it is not taken.
  assign accept_s    = stream.in_valid & in_ready_s & ~stream.load_start;
  assign lane_last_s = (lane_r == LAST_LANE);
  assign asm_next_s  = {stream.in_data, asm_r[WORD_W-1:IN_W]};

  // A partial word sits in the top lanes of asm_r; shift it down so the
  // unfilled upper lanes read as zero.
  assign flush_shift_s = (32'(LANES) - 32'(lane_r)) * 32'(IN_W);
  assign flush_word_s  = asm_r >> flush_shift_s;

  // Next-state decode, lane advance and RAM write selection.
  always_comb begin
    next_state_s = state_r;
    lane_next_s  = lane_r;
    we_s         = 1'b0;
    wdata_s      = '0;

    if (accept_s) begin
      if (lane_last_s) begin
        lane_next_s = '0;
      end else begin
        lane_next_s = lane_r + LANE_W'(1);
      end
    end else begin
      lane_next_s = lane_r;
    end

    if (accept_s && lane_last_s) begin
      we_s    = 1'b1;
      wdata_s = asm_next_s;
    end else if (state_r == ST_FLUSH && !full_s && !stream.load_start) begin
      we_s    = 1'b1;
      wdata_s = flush_word_s;
    end else begin
      we_s    = 1'b0;
      wdata_s = '0;
    end

    if (stream.load_start) begin
      next_state_s = ST_LOAD;
    end else begin
      case (state_r)
        ST_IDLE:  next_state_s = ST_IDLE;
        ST_LOAD: begin
          if (stream.load_end) begin
            // Decided on the lane count after this cycle's beat is packed.
            next_state_s = (lane_next_s == '0) ? ST_DONE : ST_FLUSH;
          end else begin
            next_state_s = ST_LOAD;
          end
        end
        ST_FLUSH: next_state_s = ST_DONE;
        ST_DONE:  next_state_s = ST_DONE;
        default:  next_state_s = ST_IDLE;
      endcase
    end
  end

  // State register plus registered status flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      loading_r   <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      loading_r   <= (next_state_s == ST_LOAD) || (next_state_s == ST_FLUSH);
      load_done_r <= (next_state_s == ST_DONE);
    end
  end

  // Load bookkeeping: assembly register, lane counter, pointer, count, overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_r        <= '0;
      lane_r       <= '0;
      wptr_r       <= '0;
      word_count_r <= '0;
      overflow_r   <= 1'b0;
    end else if (stream.load_start) begin
      asm_r        <= '0;
      lane_r       <= '0;
      wptr_r       <= '0;
      word_count_r <= '0;
      overflow_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        asm_r  <= asm_next_s;
        lane_r <= lane_next_s;
      end
      // Pointer and count only move on a real write, so they saturate at depth.
      if (we_s) begin
        wptr_r       <= wptr_r + (ADDR_W+1)'(1);
        word_count_r <= word_count_r + (ADDR_W+1)'(1);
      end
      if (state_r == ST_FLUSH) begin
        lane_r <= '0;
        asm_r  <= '0;
        if (full_s) begin
          overflow_r <= 1'b1;
        end
      end
      if (state_r == ST_LOAD && stream.in_valid && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Text RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wptr_r[ADDR_W-1:0]] <= wdata_s;
    end
  end

  // Registered read port; same-edge write is seen one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else begin
      rdata_r <= mem[raddr[ADDR_W+BOFS_W-1:BOFS_W]];
    end
  end

  assign stream.in_ready = in_ready_s;
  assign rdata           = rdata_r;
  assign loading         = loading_r;
  assign load_done       = load_done_r;
  assign word_count      = word_count_r;
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_text_stream_loader.sv
// tb_text_stream_loader: directed bench for text_stream_loader with a 4-word
// RAM (ADDR_W=2), 32-bit words and byte beats. Expected values are written
// out by hand from the little-endian packing rules.
module tb_text_stream_loader;

  localparam int ADDR_W = 2;
  localparam int WORD_W = 32;
  localparam int IN_W   = 8;
  localparam int BOFS_W = 2;

  logic                     clk;
  logic                     rst_n;
  logic [ADDR_W+BOFS_W-1:0] raddr;
  logic [WORD_W-1:0]        rdata;
  logic                     loading;
  logic                     load_done;
  logic [ADDR_W:0]          word_count;
  logic                     overflow;

  int checks;
  int errors;

  text_stream_loader_if #(.IN_W(IN_W)) bus ();

  text_stream_loader #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W),
    .IN_W  (IN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stream    (bus.slave),
    .raddr     (raddr),
    .rdata     (rdata),
    .loading   (loading),
    .load_done (load_done),
    .word_count(word_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  // Offer one beat and hold it until accepted (bounded); optional load_end.
  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.load_end = last;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    tick();
    bus.load_end = 1'b0;
  endtask

  task automatic read_word(input int w, input string tag, input logic [31:0] exp);
    raddr = 4'(w << 2);
    tick();
    check(tag, rdata, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    raddr  = '0;
    bus.load_start = 1'b0;
    bus.load_end   = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    tick();
    tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    rst_n = 1'b1;
    tick();

    // load_end in IDLE is ignored.
    bus.load_end = 1'b1;
    tick();
    bus.load_end = 1'b0;
    check("idle_end_done", 32'(load_done), 32'd0);

    // One full word, then load_end on its own.
    start_load();
    check("t1_ready", 32'(bus.in_ready), 32'd1);
    check("t1_loading", 32'(loading), 32'd1);
    send(8'h13, 1'b0);
    send(8'h05, 1'b0);
    send(8'h10, 1'b0);
    send(8'h00, 1'b0);
    bus.in_valid = 1'b0;
    bus.load_end = 1'b1;
    tick();
    bus.load_end = 1'b0;
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_count", 32'(word_count), 32'd1);
    read_word(0, "t1_word0", 32'h00100513);

    // in_valid in DONE is ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    tick();
    bus.in_valid = 1'b0;
    check("done_valid_count", 32'(word_count), 32'd1);

    // Six beats, load_end with the sixth: FLUSH writes a zero-padded word.
    start_load();
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 1'b0);
    send(8'h16, 1'b1);
    bus.in_valid = 1'b0;
    check("t2_flush_loading", 32'(loading), 32'd1);
    check("t2_flush_count", 32'(word_count), 32'd1);
    tick();
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_count", 32'(word_count), 32'd2);
    read_word(0, "t2_word0", 32'h14131211);
    read_word(1, "t2_word1", 32'h00001615);

    // Gapped valid: idle cycles show junk data that must not be packed.
    start_load();
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 3); g++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
        tick();
      end
      send(8'(8'hA0 + i), 1'b0);
      if (i == 2) check("t3_count_mid", 32'(word_count), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.load_end = 1'b1;
    tick();
    bus.load_end = 1'b0;
    check("t3_count", 32'(word_count), 32'd2);
    read_word(0, "t3_word0", 32'hA3A2A1A0);
    read_word(1, "t3_word1", 32'hA7A6A5A4);

    // Fill all four words, then a 17th beat overflows.
    start_load();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
    check("t4_count_full", 32'(word_count), 32'd4);
    check("t4_ready_full", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_count_sat", 32'(word_count), 32'd4);
    tick();
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    read_word(0, "t4_word0", 32'h03020100);
    read_word(3, "t4_word3", 32'h0F0E0D0C);
    bus.load_end = 1'b1;
    tick();
    bus.load_end = 1'b0;
    start_load();
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    check("t4_count_clr", 32'(word_count), 32'd0);

    // Read-before-write on word 1 while its last beat lands.
    for (int i = 0; i < 4; i++) send(8'(8'h21 + i), 1'b0);
    for (int i = 0; i < 3; i++) send(8'(8'h31 + i), 1'b0);
    raddr = 4'd4;
    send(8'h34, 1'b0);
    bus.in_valid = 1'b0;
    check("t6_old_word", rdata, 32'h07060504);
    tick();
    check("t6_new_word", rdata, 32'h34333231);

    // Reset mid-load: partial word dropped, earlier words kept.
    start_load();
    for (int i = 0; i < 4; i++) send(8'(8'h51 + i), 1'b0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_loading", 32'(loading), 32'd0);
    check("t5_rst_count", 32'(word_count), 32'd0);
    tick();
    rst_n = 1'b1;
    read_word(0, "t5_word0", 32'h54535251);
    read_word(1, "t5_word1", 32'h34333231);
    check("t5_ready", 32'(bus.in_ready), 32'd0);
    check("t5_done", 32'(load_done), 32'd0);
    check("t5_count", 32'(word_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
